// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant logic; the last-grant history is kept by the caller.
module rr_arbiter_2 (
    input  logic Valid0,
    input  logic Valid1,
    input  logic LastGrant,
    input  logic Enable,
    output logic Grant0,
    output logic Grant1
);

    always_comb begin
        Grant0 = 1'b0;
        Grant1 = 1'b0;
        if (Enable) begin
            if (Valid0 && Valid1) begin
                // On contention the requester that did not win last time goes first.
                Grant0 = LastGrant;
                Grant1 = !LastGrant;
            end else begin
                Grant0 = Valid0;
                Grant1 = Valid1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between the execute path (0) and the PC/address path (1),
// holding granted operands on the ALU and returning the captured result tagged by requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic [WIDTH-1:0] Req0A,
    input  logic [WIDTH-1:0] Req0B,
    input  logic [OPW-1:0]   Req0Op,
    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic [WIDTH-1:0] Req1A,
    input  logic [WIDTH-1:0] Req1B,
    input  logic [OPW-1:0]   Req1Op,
    output logic             RspValid,
    input  logic             RspReady,
    output logic             RspId,
    output logic [WIDTH-1:0] RspOut,
    output logic             RspBranch,
    output logic [WIDTH-1:0] AluInputA,
    output logic [WIDTH-1:0] AluInputB,
    output logic [OPW-1:0]   AluOp,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluShouldBranch,
    output logic             Busy
);

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_branch_q, rsp_branch_d;
    logic             grant0, grant1;

    rr_arbiter_2 u_rr (
        .Valid0    (Req0Valid),
        .Valid1    (Req1Valid),
        .LastGrant (last_grant_q),
        .Enable    (state_q == IDLE),
        .Grant0    (grant0),
        .Grant1    (grant1)
    );

    assign Req0Ready = grant0;
    assign Req1Ready = grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_branch_d = rsp_branch_q;

        case (state_q)
            IDLE: begin
                if (Req0Valid && grant0) begin
                    alu_a_d      = Req0A;
                    alu_b_d      = Req0B;
                    alu_op_d     = Req0Op;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    cnt_d        = LAT_INIT;
                    state_d      = EXEC;
                end else if (Req1Valid && grant1) begin
                    alu_a_d      = Req1A;
                    alu_b_d      = Req1B;
                    alu_op_d     = Req1Op;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    cnt_d        = LAT_INIT;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // Operands stay on the ALU; count down its latency before sampling the result.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_out_d    = AluOut;
                    rsp_branch_d = AluShouldBranch;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && RspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_branch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_branch_q <= rsp_branch_d;
        end
    end

    assign AluInputA = alu_a_q;
    assign AluInputB = alu_b_q;
    assign AluOp     = alu_op_q;
    assign RspValid  = rsp_valid_q;
    assign RspId     = rsp_id_q;
    assign RspOut    = rsp_out_q;
    assign RspBranch = rsp_branch_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: three builds (ALU_LAT 1, 0, 3) share stimulus,
// each driving its own behavioural ALU stub.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid, RspReady;
    logic [15:0] Req0A, Req0B, Req1A, Req1B;
    logic [3:0]  Req0Op, Req1Op;

    logic        r0rdy1, r1rdy1, rv1, rid1, rbr1, busy1, sb1;
    logic [15:0] rout1, aa1, ab1, aout1;
    logic [3:0]  aop1;
    logic        r0rdy0, r1rdy0, rv0, rid0, rbr0, busy0, sb0;
    logic [15:0] rout0, aa0, ab0, aout0;
    logic [3:0]  aop0;
    logic        r0rdy3, r1rdy3, rv3, rid3, rbr3, busy3, sb3;
    logic [15:0] rout3, aa3, ab3, aout3;
    logic [3:0]  aop3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        logic [15:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            ALU_XOR: r = a ^ b;
            default: r = 16'h0;
        endcase
        return {(a == b), r};
    endfunction

    // ALU stubs: latency 1 (registered), 0 (combinational), 3 (three registers)
    logic [16:0] p1;
    logic [16:0] p3 [3];
    always_ff @(posedge CLK) begin
        p1    <= alu_f(aa1, ab1, aop1);
        p3[0] <= alu_f(aa3, ab3, aop3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {sb1, aout1} = p1;
    assign {sb0, aout0} = alu_f(aa0, ab0, aop0);
    assign {sb3, aout3} = p3[2];

    alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(1)) u_dut (
        .CLK(CLK), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(r0rdy1), .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
        .Req1Valid(Req1Valid), .Req1Ready(r1rdy1), .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
        .RspValid(rv1), .RspReady(RspReady), .RspId(rid1), .RspOut(rout1), .RspBranch(rbr1),
        .AluInputA(aa1), .AluInputB(ab1), .AluOp(aop1), .AluOut(aout1),
        .AluShouldBranch(sb1), .Busy(busy1)
    );

    alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(0)) u_dut0 (
        .CLK(CLK), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(r0rdy0), .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
        .Req1Valid(Req1Valid), .Req1Ready(r1rdy0), .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
        .RspValid(rv0), .RspReady(RspReady), .RspId(rid0), .RspOut(rout0), .RspBranch(rbr0),
        .AluInputA(aa0), .AluInputB(ab0), .AluOp(aop0), .AluOut(aout0),
        .AluShouldBranch(sb0), .Busy(busy0)
    );

    alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(3)) u_dut3 (
        .CLK(CLK), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(r0rdy3), .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
        .Req1Valid(Req1Valid), .Req1Ready(r1rdy3), .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
        .RspValid(rv3), .RspReady(RspReady), .RspId(rid3), .RspOut(rout3), .RspBranch(rbr3),
        .AluInputA(aa3), .AluInputB(ab3), .AluOp(aop3), .AluOut(aout3),
        .AluShouldBranch(sb3), .Busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    // Advance until the latency-1 build shows RspValid, bounded.
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rv1 !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (rv1 !== 1'b1) check({tag, "_timeout"}, 32'(rv1), 32'd1);
    endtask

    initial begin
        Reset = 1'b1; RspReady = 1'b1;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        Req0A = '0; Req0B = '0; Req0Op = '0;
        Req1A = '0; Req1B = '0; Req1Op = '0;

        // Reset state
        do_reset();
        check("rst_busy",   32'(busy1), 32'd0);
        check("rst_rspv",   32'(rv1),   32'd0);
        check("rst_rspid",  32'(rid1),  32'd0);
        check("rst_rspout", 32'(rout1), 32'd0);
        check("rst_rspbr",  32'(rbr1),  32'd0);
        check("rst_alua",   32'(aa1),   32'd0);
        check("rst_aluop",  32'(aop1),  32'd0);

        // 1. Single request
        Req0A = 16'd1; Req0B = 16'd1; Req0Op = ALU_ADD; Req0Valid = 1'b1;
        #1;
        check("t1_rdy_pre", 32'(r0rdy1), 32'd1);
        cyc();
        Req0Valid = 1'b0;
        #1;
        check("t1_rdy_post", 32'(r0rdy1), 32'd0);
        check("t1_busy",     32'(busy1),  32'd1);
        check("t1_alua",     32'(aa1),    32'd1);
        cyc();
        check("t1_rspv_c1",  32'(rv1),    32'd0);
        cyc();
        check("t1_rspv_c2",  32'(rv1),    32'd1);
        check("t1_rspout",   32'(rout1),  32'd2);
        check("t1_rspid",    32'(rid1),   32'd0);
        check("t1_rspbr",    32'(rbr1),   32'd1);
        cyc();
        check("t1_busy_end", 32'(busy1),  32'd0);
        check("t1_rspv_end", 32'(rv1),    32'd0);

        // 2. Contention: grant order 0,1,0,1
        do_reset();
        Req0A = 16'd5; Req0B = 16'd3; Req0Op = ALU_SUB;
        Req1A = 16'd6; Req1B = 16'd3; Req1Op = ALU_XOR;
        Req0Valid = 1'b1; Req1Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            wait_rsp("t2");
            check($sformatf("t2_id%0d", i),  32'(rid1),  32'(i % 2));
            check($sformatf("t2_out%0d", i), 32'(rout1), (i % 2 == 1) ? 32'd5 : 32'd2);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        cyc();

        // 3. Backpressure
        do_reset();
        RspReady = 1'b0;
        Req1A = 16'd7; Req1B = 16'd7; Req1Op = ALU_ADD; Req1Valid = 1'b1;
        cyc();
        Req0A = 16'd1; Req0B = 16'd2; Req0Op = ALU_OR; Req0Valid = 1'b1;
        wait_rsp("t3");
        for (int i = 0; i < 5; i++) begin
            check("t3_rspv",  32'(rv1),    32'd1);
            check("t3_out",   32'(rout1),  32'd14);
            check("t3_id",    32'(rid1),   32'd1);
            check("t3_br",    32'(rbr1),   32'd1);
            check("t3_r0rdy", 32'(r0rdy1), 32'd0);
            check("t3_r1rdy", 32'(r1rdy1), 32'd0);
            cyc();
        end
        RspReady = 1'b1;
        cyc();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        check("t3_rspv_end", 32'(rv1),   32'd0);
        check("t3_busy_end", 32'(busy1), 32'd0);

        // 4. Operand stability
        do_reset();
        Req0A = 16'd1; Req0B = 16'd2; Req0Op = ALU_OR; Req0Valid = 1'b1;
        cyc();
        Req0Valid = 1'b0;
        cyc();
        Req0A = 16'd9;
        for (int i = 0; i < 3; i++) begin
            check("t4_alua", 32'(aa1), 32'd1);
            if (rv1 === 1'b1) break;
            cyc();
        end
        wait_rsp("t4");
        check("t4_out",  32'(rout1), 32'd3);
        check("t4_br",   32'(rbr1),  32'd0);
        cyc();

        // 5. Reset mid-op
        do_reset();
        Req0A = 16'd3; Req0B = 16'd3; Req0Op = ALU_ADD; Req0Valid = 1'b1;
        cyc();
        Req0Valid = 1'b0;
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("t5_rspv", 32'(rv1),   32'd0);
        check("t5_busy", 32'(busy1), 32'd0);
        check("t5_alua", 32'(aa1),   32'd0);
        check("t5_alub", 32'(ab1),   32'd0);
        check("t5_aluop", 32'(aop1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t5_norsp", 32'(rv1), 32'd0);
        end
        Req0A = 16'd2; Req0B = 16'd3; Req0Op = ALU_ADD; Req0Valid = 1'b1;
        Req1A = 16'd8; Req1B = 16'd1; Req1Op = ALU_SUB; Req1Valid = 1'b1;
        #1;
        check("t5_r0rdy", 32'(r0rdy1), 32'd1);
        check("t5_r1rdy", 32'(r1rdy1), 32'd0);
        cyc();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        wait_rsp("t5");
        check("t5_id",  32'(rid1),  32'd0);
        check("t5_out", 32'(rout1), 32'd5);
        cyc();

        // 6. Latency 0 / 1 / 3 builds side by side
        do_reset();
        Req1A = 16'd4; Req1B = 16'd4; Req1Op = ALU_AND; Req1Valid = 1'b1;
        cyc();
        Req1Valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check($sformatf("t6_l0_v%0d", k), 32'(rv0), 32'(k == 1));
            check($sformatf("t6_l1_v%0d", k), 32'(rv1), 32'(k == 2));
            check($sformatf("t6_l3_v%0d", k), 32'(rv3), 32'(k == 4));
            if (k == 1) begin
                check("t6_l0_out", 32'(rout0), 32'd4);
                check("t6_l0_br",  32'(rbr0),  32'd1);
                check("t6_l0_id",  32'(rid0),  32'd1);
            end
            if (k == 4) begin
                check("t6_l3_out", 32'(rout3), 32'd4);
                check("t6_l3_br",  32'(rbr3),  32'd1);
                check("t6_l3_id",  32'(rid3),  32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
